// File: rtl/isp_pkg.sv
// Shared definitions for the ISP chroma path: mode encodings and a
// constant-foldable ceil(log2) helper for sizing pointers and counters.
package isp_pkg;

    // Operating modes as seen on the mode input; code 3 behaves like GREY.
    typedef enum logic [1:0] {
        MODE_ALIGN    = 2'd0,
        MODE_GREY     = 2'd1,
        MODE_FLUSH    = 2'd2,
        MODE_GREY_ALT = 2'd3
    } mode_e;

    // ceil(log2(value)); usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/isp_chroma_align_if.sv
// Pixel stream bundle for the chroma aligner: chroma source, delayed luma
// and the re-timed output stream. The slave side is the aligner itself.
interface isp_chroma_align_if #(
    parameter int BITS = 8,
    parameter int CH   = 2
);
    logic                 src_href;
    logic                 src_vsync;
    logic [CH*BITS-1:0]   src_chroma;
    logic                 y_href;
    logic                 y_vsync;
    logic [BITS-1:0]      y_data;
    logic                 out_href;
    logic                 out_vsync;
    logic [BITS-1:0]      out_y;
    logic [CH*BITS-1:0]   out_chroma;

    modport master (
        output src_href, src_vsync, src_chroma,
        output y_href, y_vsync, y_data,
        input  out_href, out_vsync, out_y, out_chroma
    );

    modport slave (
        input  src_href, src_vsync, src_chroma,
        input  y_href, y_vsync, y_data,
        output out_href, out_vsync, out_y, out_chroma
    );
endinterface

// File: rtl/isp_sync_fifo.sv
// Single-clock FIFO on a simple dual-port RAM with a registered read port.
// Pop data appears one cycle after rd_fire. A read only happens when the
// FIFO held data at the start of the cycle, so a same-cycle write can never
// be read back immediately; a full FIFO accepts a write if it also pops.
module isp_sync_fifo
    import isp_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_fire,
    output logic             wr_drop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q,  level_d;
    logic             wr_fire;

    // Accept/reject decisions and next pointer/occupancy values.
    always_comb begin
        rd_fire  = rd_req && !flush && (level_q != '0);
        wr_fire  = wr_req && !flush && ((level_q != FULL) || rd_fire);
        wr_drop  = wr_req && !flush && (level_q == FULL) && !rd_fire;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + (AW+1)'(wr_fire) - (AW+1)'(rd_fire);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // RAM array: no reset, read-before-write when full and both ports hit one word.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (rd_fire) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;

endmodule

// File: rtl/isp_chroma_align.sv
// Chroma aligner: buffers chroma pixels and hands each one out alongside the
// luma pixel of the same ordinal position, whatever the lag between the two
// streams. Luma and sync pass through with one register stage.
module isp_chroma_align
    import isp_pkg::*;
#(
    parameter int  BITS    = 8,
    parameter int  CH      = 2,
    parameter int  DEPTH   = 16384,
    parameter int  NEUTRAL = 2**(BITS-1),
    localparam int AW      = clog2(DEPTH),
    localparam int W       = CH*BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    isp_chroma_align_if.slave   bus,
    output logic                ovf,
    output logic                udf,
    output logic [AW:0]         level
);

    localparam logic [BITS-1:0] NEUTRAL_S = BITS'(NEUTRAL);

    logic [W-1:0]    neutral_vec;
    logic [W-1:0]    fifo_rd_data;
    logic            rd_fire;
    logic            wr_drop;

    mode_e           mode_q, mode_d, mode_eff;
    logic            y_vsync_prev_q, y_vsync_prev_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            out_href_q, out_href_d;
    logic            out_vsync_q, out_vsync_d;
    logic [BITS-1:0] out_y_q, out_y_d;
    logic            pop_q, pop_d;
    logic [W-1:0]    chroma_hold_q, chroma_hold_d;
    logic            vs_rise;
    logic            flush;
    logic            grey;
    logic            udf_event;

    // Grey value replicated across every chroma channel.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_neutral
            assign neutral_vec[gi*BITS +: BITS] = NEUTRAL_S;
        end
    endgenerate

    isp_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_req  (bus.src_href),
        .wr_data (bus.src_chroma),
        .rd_req  (bus.y_href),
        .rd_fire (rd_fire),
        .wr_drop (wr_drop),
        .rd_data (fifo_rd_data),
        .level   (level)
    );

    // Frame-level mode latch, sticky error flags and output pipeline.
    always_comb begin
        vs_rise        = bus.y_vsync && !y_vsync_prev_q;
        mode_eff       = vs_rise ? mode_e'(mode) : mode_q;
        flush          = (mode_eff == MODE_FLUSH);
        grey           = (mode_eff == MODE_GREY) || (mode_eff == MODE_GREY_ALT);
        udf_event      = bus.y_href && !flush && (level == '0);

        mode_d         = mode_eff;
        y_vsync_prev_d = bus.y_vsync;
        // A new error in the clearing cycle keeps its flag set.
        ovf_d          = vs_rise ? wr_drop   : (ovf_q || wr_drop);
        udf_d          = vs_rise ? udf_event : (udf_q || udf_event);

        out_href_d     = bus.y_href;
        out_vsync_d    = bus.y_vsync;
        out_y_d        = bus.y_data;

        // pop_q selects the RAM read register as the chroma source; otherwise
        // the hold register supplies either the last popped pixel or grey.
        pop_d          = rd_fire && !grey;
        chroma_hold_d  = pop_q ? fifo_rd_data : chroma_hold_q;
        if (bus.y_href && !pop_d) begin
            chroma_hold_d = neutral_vec;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= MODE_ALIGN;
            y_vsync_prev_q <= 1'b0;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
            out_href_q     <= 1'b0;
            out_vsync_q    <= 1'b0;
            out_y_q        <= '0;
            pop_q          <= 1'b0;
            chroma_hold_q  <= neutral_vec;
        end else begin
            mode_q         <= mode_d;
            y_vsync_prev_q <= y_vsync_prev_d;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
            out_href_q     <= out_href_d;
            out_vsync_q    <= out_vsync_d;
            out_y_q        <= out_y_d;
            pop_q          <= pop_d;
            chroma_hold_q  <= chroma_hold_d;
        end
    end

    assign bus.out_href   = out_href_q;
    assign bus.out_vsync  = out_vsync_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_chroma = pop_q ? fifo_rd_data : chroma_hold_q;
    assign ovf            = ovf_q;
    assign udf            = udf_q;

endmodule

// File: tb/tb_isp_chroma_align.sv
// Bench for isp_chroma_align: directed scenarios followed by randomized
// frames. A queue-based reference model predicts each output pixel; a monitor
// pops and compares whenever the DUT presents out_href.
module tb_isp_chroma_align;
    import isp_pkg::*;

    localparam int BITS    = 8;
    localparam int CH      = 2;
    localparam int DEPTH   = 16;
    localparam int NEUTRAL = 128;
    localparam logic [15:0] NEUT16 = 16'h8080;

    typedef struct {
        logic [7:0]  y;
        logic [15:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       ovf;
    logic       udf;
    logic [4:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        exp_q[$];
    logic [15:0] fifo_m[$];
    int          m_mode;
    logic        m_ovf, m_udf, m_prev_vs, m_vsync;
    logic [15:0] m_hold;

    isp_chroma_align_if #(.BITS(BITS), .CH(CH)) bus();

    isp_chroma_align #(
        .BITS    (BITS),
        .CH      (CH),
        .DEPTH   (DEPTH),
        .NEUTRAL (NEUTRAL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .bus   (bus),
        .ovf   (ovf),
        .udf   (udf),
        .level (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference model: chroma FIFO as a plain queue, rules applied per cycle.
    initial begin
        logic        vs_rise, flush, grey, got;
        logic [15:0] popped, chroma;
        exp_t        e;
        forever begin
            @(posedge clk);
            if (rst) begin
                fifo_m.delete();
                exp_q.delete();
                m_mode = 0; m_ovf = 0; m_udf = 0; m_prev_vs = 0; m_vsync = 0;
                m_hold = NEUT16;
            end else begin
                vs_rise   = bus.y_vsync && !m_prev_vs;
                m_prev_vs = bus.y_vsync;
                m_vsync   = bus.y_vsync;
                if (vs_rise) begin
                    m_mode = int'(mode); m_ovf = 0; m_udf = 0;
                end
                flush  = (m_mode == 2);
                grey   = (m_mode == 1) || (m_mode == 3);
                got    = 0;
                popped = NEUT16;
                if (flush) begin
                    fifo_m.delete();
                end else begin
                    got = bus.y_href && (fifo_m.size() > 0);
                    if (bus.y_href && !got) m_udf = 1;
                    if (got) popped = fifo_m.pop_front();
                    if (bus.src_href) begin
                        if (fifo_m.size() < DEPTH) fifo_m.push_back(bus.src_chroma);
                        else m_ovf = 1;
                    end
                end
                chroma = (got && !grey) ? popped : NEUT16;
                if (bus.y_href) begin
                    e.y = bus.y_data; e.c = chroma;
                    exp_q.push_back(e);
                    m_hold = chroma;
                end
            end
        end
    end

    // Monitor: compares state every cycle and pops the scoreboard on out_href.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("level", 32'(level), 32'(fifo_m.size()));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("udf", 32'(udf), 32'(m_udf));
            check("out_vsync", 32'(bus.out_vsync), 32'(m_vsync));
            if (bus.out_href) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_href", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_y", 32'(bus.out_y), 32'(e.y));
                    check("out_chroma", 32'(bus.out_chroma), 32'(e.c));
                    $display("txn t=%0t y=%02h chroma=%04h level=%0d", $time, bus.out_y, bus.out_chroma, level);
                end
            end else begin
                check("hold_chroma", 32'(bus.out_chroma), 32'(m_hold));
            end
        end
    end

    logic       cur_vs;
    logic [1:0] cur_md;

    task automatic drive(input logic sh, input logic [15:0] sc, input logic yh, input logic [7:0] yd);
        bus.src_href = sh; bus.src_chroma = sc;
        bus.y_href = yh; bus.y_data = yd;
        bus.y_vsync = cur_vs; mode = cur_md;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 8'h0);
    endtask

    task automatic vsync_pulse(input logic [1:0] md);
        cur_md = md; cur_vs = 1'b1;
        idle(1);
        cur_vs = 1'b0;
        idle(1);
    endtask

    // Stimulus.
    initial begin
        int psrc, py;
        rst = 1'b1; mode = 2'd0; cur_vs = 1'b0; cur_md = 2'd0;
        bus.src_href = 0; bus.src_vsync = 0; bus.src_chroma = '0;
        bus.y_href = 0; bus.y_vsync = 0; bus.y_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Basic alignment with 20-cycle luma lag.
        vsync_pulse(2'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, {8'(110 + i), 8'(10 + i)}, 1'b0, 8'h0);
        idle(20);
        for (int i = 0; i < 6; i++) drive(1'b0, 16'h0, 1'b1, 8'(20 + i));
        idle(3);

        // Overflow: 17 writes, then drain 16.
        for (int i = 0; i < 17; i++) drive(1'b1, {8'(100 + i), 8'(i + 1)}, 1'b0, 8'h0);
        idle(2);
        for (int i = 0; i < 16; i++) drive(1'b0, 16'h0, 1'b1, 8'(40 + i));
        idle(2);

        // Empty FIFO with simultaneous write and read.
        vsync_pulse(2'd0);
        drive(1'b1, 16'hABCD, 1'b1, 8'h33);
        idle(1);
        drive(1'b0, 16'h0, 1'b1, 8'h34);
        idle(2);

        // Mode change mid-frame takes effect at next vsync rise only.
        for (int i = 0; i < 4; i++) drive(1'b1, {8'(200 + i), 8'(60 + i)}, 1'b0, 8'h0);
        cur_md = 2'd1;
        drive(1'b0, 16'h0, 1'b1, 8'h50);
        drive(1'b0, 16'h0, 1'b1, 8'h51);
        vsync_pulse(2'd1);
        drive(1'b1, 16'h1122, 1'b1, 8'h52);
        drive(1'b0, 16'h0, 1'b1, 8'h53);
        drive(1'b0, 16'h0, 1'b1, 8'h54);
        drive(1'b0, 16'h0, 1'b1, 8'h55);
        idle(2);
        vsync_pulse(2'd0);

        // Flush with data buffered.
        for (int i = 0; i < 5; i++) drive(1'b1, {8'(i), 8'(70 + i)}, 1'b0, 8'h0);
        vsync_pulse(2'd2);
        drive(1'b1, 16'h5566, 1'b0, 8'h0);
        drive(1'b1, 16'h7788, 1'b1, 8'h60);
        idle(2);
        vsync_pulse(2'd0);

        // Reset while holding 7 pixels.
        for (int i = 0; i < 7; i++) drive(1'b1, {8'(i), 8'(90 + i)}, 1'b0, 8'h0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        drive(1'b1, 16'h4321, 1'b0, 8'h0);
        drive(1'b0, 16'h0, 1'b1, 8'h70);
        idle(2);

        // Randomized frames with varying stream rates and modes.
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 9))
                0:       vsync_pulse(2'd2);
                1, 2:    vsync_pulse(2'd1);
                3:       vsync_pulse(2'd3);
                default: vsync_pulse(2'd0);
            endcase
            psrc = $urandom_range(20, 80);
            py   = $urandom_range(20, 80);
            for (int i = 0; i < 150; i++) begin
                drive(($urandom_range(0, 99) < psrc), 16'($urandom),
                      ($urandom_range(0, 99) < py), 8'($urandom));
                if ($urandom_range(0, 99) == 0) cur_md = 2'($urandom);
            end
            if (f == 10) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
        end
        idle(4);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/isp_chroma_align.md
ISP_CHROMA_ALIGN -- requirements
Module: isp_chroma_align

Interface
REQ-001 Parameters: BITS, default 8, sample width; CH, default 2, chroma channel count; DEPTH, default 16384, FIFO depth in pixels (power of 2, >=4); NEUTRAL, default 2**(BITS-1), grey chroma value.
REQ-002 clk  in  1  pixel clock; the only clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mode  in  2  0=ALIGN, 1=GREY, 2=FLUSH, 3=GREY.
REQ-005 src_href  in  1  chroma-source pixel valid.
REQ-006 src_vsync  in  1  chroma-source frame sync (informational, unused by datapath).
REQ-007 src_chroma  in  CH*BITS  chroma pixel; channel 0 in the LSBs.
REQ-008 y_href  in  1  delayed-luma pixel valid.
REQ-009 y_vsync  in  1  delayed-luma frame sync.
REQ-010 y_data  in  BITS  delayed luma.
REQ-011 out_href / out_vsync  out  1 each  y_href / y_vsync delayed 1 cycle.
REQ-012 out_y  out  BITS  y_data delayed 1 cycle.
REQ-013 out_chroma  out  CH*BITS  chroma matched to out_y.
REQ-014 ovf / udf  out  1 each  sticky overflow / underflow flags.
REQ-015 level  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 Block SHALL pair each luma pixel with the chroma pixel written in the same ordinal position, independent of the latency between the two streams.
REQ-017 Write SHALL occur on a cycle with src_href=1 and level<DEPTH, or level=DEPTH with a read in the same cycle.
REQ-018 src_href=1 at level=DEPTH with no read SHALL drop the sample and set ovf.
REQ-019 Read SHALL occur on a cycle with y_href=1 and level>0 at that cycle's start; a same-cycle write does not count.
REQ-020 y_href=1 at level=0 SHALL set udf, pop nothing, and give out_chroma=NEUTRAL on all channels next cycle.
REQ-021 Latency y_* -> out_* SHALL be exactly 1 cycle, all outputs registered.
REQ-022 level SHALL update every cycle as level + write - read, with wrap-free pointers of clog2(DEPTH) bits.
REQ-023 Mode SHALL be sampled only on a y_vsync rising edge (0->1) and held for the frame; the edge cycle already uses the new mode.
REQ-024 ALIGN: out_chroma = popped data.
REQ-025 GREY: FIFO operates as in ALIGN, preserving alignment; out_chroma forced to NEUTRAL.
REQ-026 FLUSH: pointers and level held at 0, writes discarded, out_chroma=NEUTRAL, ovf/udf not set.
REQ-027 ovf and udf SHALL clear on a y_vsync rising edge; a same-cycle new error event SHALL win (flag stays 1).
REQ-028 out_chroma SHALL hold its last value while out_href=0.

Reset
REQ-029 With rst=1 at a clock edge: pointers=0, level=0, ovf=udf=0, out_href=out_vsync=0, out_y=0, out_chroma=NEUTRAL, latched mode=ALIGN.
REQ-030 Reset mid-frame SHALL discard FIFO contents; the first pixel written after reset pairs with the first read after reset.
REQ-031 FIFO RAM contents need not be reset.

Structure
REQ-032 Shared package isp_pkg SHALL hold mode encodings (MODE_ALIGN, MODE_GREY, MODE_FLUSH) and a clog2 function.
REQ-033 Storage SHALL be sub-module isp_sync_fifo: single clock, simple dual-port RAM, registered read data, 1-cycle read latency, inferable as block RAM.

Verification
REQ-034 BITS=8, CH=2, DEPTH=16, ALIGN: write 6 chroma pixels u=10..15, v=110..115, then 6 luma reads 20 cycles later -> out_chroma u=10..15 / v=110..115 in order, each 1 cycle after its y_href; level back to 0; ovf=udf=0.
REQ-035 DEPTH=16: 17 writes, no reads -> level=16, ovf=1; the 17th sample is lost; 16 reads return samples 1..16.
REQ-036 Empty FIFO, y_href and src_href both 1 in the same cycle -> udf=1, out_chroma=0x80 0x80, level=1 next cycle; the next read returns the written sample.
REQ-037 mode driven 1 mid-frame -> output unchanged until the next y_vsync rise; after it, out_chroma=0x80 while level still tracks; the following y_vsync rise clears a set udf.
REQ-038 mode=2 latched with level=5 -> level=0 within 1 cycle; writes ignored; no flags set.
REQ-039 rst pulsed while level=7 -> level=0, out_href=0, out_chroma=0x80 next cycle; a fresh write/read pair aligns correctly.
